bullet_motion: RTL and testbench

- Per-bullet motion controller on the far side of the wall-collision detector.
- Consumes the detector's isWall* flags once per frame and reflects the bullet's velocity.
- Produces the bullet position, size and motion vector that feed back into the detector and the renderer.
- Handles firing, flight lifetime, bounce limit, tank hit and re-fire cooldown.

---
 rtl/bullet_motion.sv | 160 ++++++++++++++++
 tb/tb_bullet_motion.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bullet_motion.sv
// Per-bullet motion controller: launch, wall reflection, clamped movement,
// lifetime / bounce-limit / hit kill, and re-fire cooldown. One edge per frame.
module bullet_motion #(
  parameter int unsigned BULLET_S   = 2,
  parameter int unsigned LIFETIME   = 600,
  parameter int unsigned MAX_BOUNCE = 5,
  parameter int unsigned COOLDOWN   = 30,
  parameter int unsigned X_MAX      = 639,
  parameter int unsigned Y_MAX      = 479
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire,
  input  logic       hit,
  input  logic [9:0] SpawnX,
  input  logic [9:0] SpawnY,
  input  logic [9:0] FireX_Motion,
  input  logic [9:0] FireY_Motion,
  input  logic       isWallBottom,
  input  logic       isWallTop,
  input  logic       isWallRight,
  input  logic       isWallLeft,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] BulletS,
  output logic [9:0] X_Motion,
  output logic [9:0] Y_Motion,
  output logic       bullet_on,
  output logic [2:0] bounce_count
);

  localparam int unsigned LifeW = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
  localparam int unsigned CoolW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic signed [10:0] PosLo = 11'(BULLET_S);
  localparam logic signed [10:0] XHi   = 11'(X_MAX - BULLET_S);
  localparam logic signed [10:0] YHi   = 11'(Y_MAX - BULLET_S);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_COOLDOWN
  } state_t;

  state_t           state, stateNext;
  logic [LifeW-1:0] lifeCnt, lifeNext;
  logic [CoolW-1:0] coolCnt, coolNext;
  logic [9:0]       xNext, yNext, xmNext, ymNext;
  logic             onNext;
  logic [2:0]       bounceNext;

  logic             reflX, reflY, reflect, kill;
  logic [9:0]       xmRefl, ymRefl;

  // Signed 11-bit step then clamp into the visible band; never wraps.
  function automatic logic [9:0] stepClamp(input logic [9:0] pos,
                                           input logic [9:0] mot,
                                           input logic signed [10:0] lo,
                                           input logic signed [10:0] hi);
    logic signed [10:0] sum;
    sum = $signed({1'b0, pos}) + $signed({mot[9], mot});
    if (sum < lo)      return lo[9:0];
    else if (sum > hi) return hi[9:0];
    else               return sum[9:0];
  endfunction

  assign BulletS = 10'(BULLET_S);

  // A flag reflects only when motion points into that wall.
  assign reflY   = (isWallTop && Y_Motion[9]) ||
                   (isWallBottom && !Y_Motion[9] && (Y_Motion != '0));
  assign reflX   = (isWallLeft && X_Motion[9]) ||
                   (isWallRight && !X_Motion[9] && (X_Motion != '0));
  assign reflect = reflX || reflY;
  assign xmRefl  = reflX ? (10'd0 - X_Motion) : X_Motion;
  assign ymRefl  = reflY ? (10'd0 - Y_Motion) : Y_Motion;
  assign kill    = hit || (lifeCnt == LifeW'(LIFETIME - 1)) ||
                   (reflect && (bounce_count == 3'(MAX_BOUNCE)));

  // State and output registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state        <= S_IDLE;
      BulletX      <= '0;
      BulletY      <= '0;
      X_Motion     <= '0;
      Y_Motion     <= '0;
      bullet_on    <= 1'b0;
      bounce_count <= '0;
      lifeCnt      <= '0;
      coolCnt      <= '0;
    end else begin
      state        <= stateNext;
      BulletX      <= xNext;
      BulletY      <= yNext;
      X_Motion     <= xmNext;
      Y_Motion     <= ymNext;
      bullet_on    <= onNext;
      bounce_count <= bounceNext;
      lifeCnt      <= lifeNext;
      coolCnt      <= coolNext;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext  = state;
    xNext      = BulletX;
    yNext      = BulletY;
    xmNext     = X_Motion;
    ymNext     = Y_Motion;
    onNext     = bullet_on;
    bounceNext = bounce_count;
    lifeNext   = lifeCnt;
    coolNext   = coolCnt;

    case (state)
      S_IDLE: begin
        if (fire && ((FireX_Motion != '0) || (FireY_Motion != '0))) begin
          stateNext  = S_FLIGHT;
          xNext      = SpawnX;
          yNext      = SpawnY;
          xmNext     = FireX_Motion;
          ymNext     = FireY_Motion;
          onNext     = 1'b1;
          bounceNext = '0;
          lifeNext   = '0;
        end
      end

      S_FLIGHT: begin
        if (kill) begin
          stateNext = S_COOLDOWN;
          onNext    = 1'b0;
          xmNext    = '0;
          ymNext    = '0;
          coolNext  = '0;
        end else begin
          xmNext   = xmRefl;
          ymNext   = ymRefl;
          xNext    = stepClamp(BulletX, xmRefl, PosLo, XHi);
          yNext    = stepClamp(BulletY, ymRefl, PosLo, YHi);
          lifeNext = lifeCnt + LifeW'(1);
          if (reflect && (bounce_count < 3'(MAX_BOUNCE)))
            bounceNext = bounce_count + 3'd1;
        end
      end

      S_COOLDOWN: begin
        if (coolCnt == CoolW'(COOLDOWN - 1))
          stateNext = S_IDLE;
        else
          coolNext = coolCnt + CoolW'(1);
      end

      default: stateNext = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bullet_motion.sv
// Directed bench for bullet_motion: vector table plus lifetime/cooldown sequence.
module tb_bullet_motion;

  logic       frame_clk;
  logic       Reset, fire, hit;
  logic [9:0] SpawnX, SpawnY, FireX_Motion, FireY_Motion;
  logic       isWallBottom, isWallTop, isWallRight, isWallLeft;
  logic [9:0] BulletX, BulletY, BulletS, X_Motion, Y_Motion;
  logic       bullet_on;
  logic [2:0] bounce_count;

  int tests  = 0;
  int failed = 0;

  bullet_motion dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .fire         (fire),
    .hit          (hit),
    .SpawnX       (SpawnX),
    .SpawnY       (SpawnY),
    .FireX_Motion (FireX_Motion),
    .FireY_Motion (FireY_Motion),
    .isWallBottom (isWallBottom),
    .isWallTop    (isWallTop),
    .isWallRight  (isWallRight),
    .isWallLeft   (isWallLeft),
    .BulletX      (BulletX),
    .BulletY      (BulletY),
    .BulletS      (BulletS),
    .X_Motion     (X_Motion),
    .Y_Motion     (Y_Motion),
    .bullet_on    (bullet_on),
    .bounce_count (bounce_count)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // walls = {bottom, top, right, left}
  typedef struct {
    logic       rst, fr, ht;
    logic [3:0] walls;
    logic [9:0] sx, sy, fx, fy;
    logic       on;
    logic [9:0] x, y, xm, ym;
    logic [2:0] bc;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic fr, input logic ht,
                        input logic [3:0] walls,
                        input int sx, input int sy, input int fx, input int fy,
                        input logic on, input int x, input int y,
                        input int xm, input int ym, input int bc);
    vec_t v;
    v.rst = rst; v.fr = fr; v.ht = ht; v.walls = walls;
    v.sx = 10'(sx); v.sy = 10'(sy); v.fx = 10'(fx); v.fy = 10'(fy);
    v.on = on; v.x = 10'(x); v.y = 10'(y); v.xm = 10'(xm); v.ym = 10'(ym);
    v.bc = 3'(bc);
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic applyVec(input vec_t v, input int idx);
    Reset        = v.rst;
    fire         = v.fr;
    hit          = v.ht;
    isWallBottom = v.walls[3];
    isWallTop    = v.walls[2];
    isWallRight  = v.walls[1];
    isWallLeft   = v.walls[0];
    SpawnX       = v.sx;
    SpawnY       = v.sy;
    FireX_Motion = v.fx;
    FireY_Motion = v.fy;
    tick();
    checkVal($sformatf("vec%0d {on,x,y,xm,ym,bc}", idx),
             64'({bullet_on, BulletX, BulletY, X_Motion, Y_Motion, bounce_count}),
             64'({v.on, v.x, v.y, v.xm, v.ym, v.bc}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; fire = 1'b0; hit = 1'b0;
    isWallBottom = 1'b0; isWallTop = 1'b0; isWallRight = 1'b0; isWallLeft = 1'b0;
    SpawnX = '0; SpawnY = '0; FireX_Motion = '0; FireY_Motion = '0;

    //      rst fire hit walls    sx   sy   fx   fy   on  x    y    xm   ym  bc
    addVec(1, 0, 0, 4'b0000, 100, 200,   3,  -2, 0,   0,   0,   0,  0, 0); // reset
    addVec(0, 1, 0, 4'b0000, 100, 200,   3,  -2, 1, 100, 200,   3, -2, 0); // launch
    addVec(0, 0, 0, 4'b0000, 100, 200,   3,  -2, 1, 103, 198,   3, -2, 0); // move
    addVec(0, 1, 0, 4'b0000, 100, 200,   3,  -2, 1, 106, 196,   3, -2, 0); // fire ignored
    addVec(0, 0, 0, 4'b0100, 100, 200,   3,  -2, 1, 109, 198,   3,  2, 1); // top bounce
    addVec(0, 0, 0, 4'b0100, 100, 200,   3,  -2, 1, 112, 200,   3,  2, 1); // held top: none
    addVec(0, 0, 0, 4'b0010, 100, 200,   3,  -2, 1, 109, 202,  -3,  2, 2); // right bounce
    addVec(0, 0, 0, 4'b0010, 100, 200,   3,  -2, 1, 106, 204,  -3,  2, 2); // held right
    addVec(0, 0, 0, 4'b1001, 100, 200,   3,  -2, 1, 109, 202,   3, -2, 3); // corner, +1 only
    addVec(0, 0, 0, 4'b0101, 100, 200,   3,  -2, 1, 112, 204,   3,  2, 4); // only top qualifies
    addVec(0, 0, 0, 4'b1000, 100, 200,   3,  -2, 1, 115, 202,   3, -2, 5); // 5th bounce
    addVec(0, 0, 0, 4'b0010, 100, 200,   3,  -2, 0, 115, 202,   0,  0, 5); // 6th kills
    addVec(0, 1, 0, 4'b0000, 100, 200,   3,  -2, 0, 115, 202,   0,  0, 5); // cooldown ignores fire
    addVec(1, 0, 0, 4'b0000, 100, 200,   3,  -2, 0,   0,   0,   0,  0, 0); // reset
    addVec(0, 1, 0, 4'b0000, 100, 200,   0,   0, 0,   0,   0,   0,  0, 0); // zero vector ignored
    addVec(0, 1, 0, 4'b0000,   5, 100, -10,   0, 1,   5, 100, -10,  0, 0); // launch near left
    addVec(0, 0, 0, 4'b0000,   5, 100, -10,   0, 1,   2, 100, -10,  0, 0); // clamp low X
    addVec(0, 0, 0, 4'b0000,   5, 100, -10,   0, 1,   2, 100, -10,  0, 0); // stays clamped
    addVec(0, 0, 1, 4'b0000,   5, 100, -10,   0, 0,   2, 100,   0,  0, 0); // hit kills
    addVec(1, 0, 0, 4'b0000,   5, 100, -10,   0, 0,   0,   0,   0,  0, 0); // reset in cooldown
    addVec(0, 1, 0, 4'b0000, 300, 300,   1,   1, 1, 300, 300,   1,  1, 0); // launch
    addVec(1, 0, 0, 4'b0000, 300, 300,   1,   1, 0,   0,   0,   0,  0, 0); // reset mid-flight
    addVec(1, 1, 0, 4'b0000, 300, 300,   1,   1, 0,   0,   0,   0,  0, 0); // reset beats fire
    addVec(0, 1, 0, 4'b0000, 630, 470,  20,  20, 1, 630, 470,  20, 20, 0); // launch near corner
    addVec(0, 0, 0, 4'b0000, 630, 470,  20,  20, 1, 637, 477,  20, 20, 0); // clamp high X/Y
    addVec(1, 0, 0, 4'b0000, 630, 470,  20,  20, 0,   0,   0,   0,  0, 0); // reset

    for (int i = 0; i < vecs.size(); i++) applyVec(vecs[i], i);

    checkVal("BulletS", 64'(BulletS), 64'd2);

    // Lifetime expiry and cooldown with fire held high the whole time.
    hit = 1'b0;
    isWallBottom = 1'b0; isWallTop = 1'b0; isWallRight = 1'b0; isWallLeft = 1'b0;
    SpawnX = 10'd100; SpawnY = 10'd200; FireX_Motion = 10'd1; FireY_Motion = 10'd0;
    Reset = 1'b1; fire = 1'b0;
    tick();
    Reset = 1'b0; fire = 1'b1;
    tick();
    checkVal("life launch on", 64'(bullet_on), 64'd1);
    for (int e = 1; e <= 599; e++) begin
      tick();
      checkVal($sformatf("life flight edge %0d on", e), 64'(bullet_on), 64'd1);
    end
    tick();
    checkVal("life expiry on", 64'(bullet_on), 64'd0);
    checkVal("life expiry x", 64'(BulletX), 64'd637);
    checkVal("life expiry xm", 64'(X_Motion), 64'd0);
    for (int c = 1; c <= 30; c++) begin
      tick();
      checkVal($sformatf("cooldown edge %0d on", c), 64'(bullet_on), 64'd0);
    end
    tick();
    checkVal("relaunch on", 64'(bullet_on), 64'd1);
    checkVal("relaunch x", 64'(BulletX), 64'd100);
    checkVal("relaunch bc", 64'(bounce_count), 64'd0);
    fire = 1'b0;
    tick();
    checkVal("relaunch move x", 64'(BulletX), 64'd101);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
